bpc_byte_packer: RTL and testbench

// Consumes the serialized MQ byte stream produced by the 10-lane FIFO read arbiter (fifo_out/rd_vld)
// and packs it into 32-bit big-endian codestream words for the tier-2 / output DMA stage.

---
 rtl/bpc_byte_packer_pkg.sv | 29 ++
 rtl/bpc_word_fifo.sv | 52 +++++
 rtl/bpc_byte_packer.sv | 118 +++++++++++
 tb/tb_bpc_byte_packer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bpc_byte_packer_pkg.sv
// Shared types for the byte packer: FSM states, the FIFO word layout and the
// partial-word byte-enable helper.
package bpc_byte_packer_pkg;

  localparam int BPC_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2
  } bpc_state_t;

  typedef struct packed {
    logic        last;
    logic [3:0]  be;
    logic [31:0] data;
  } bpc_word_t;

  // MSB-aligned enable mask for a word holding pos bytes
  function automatic logic [3:0] part_be(input logic [1:0] pos);
    case (pos)
      2'd1:    part_be = 4'h8;
      2'd2:    part_be = 4'hC;
      2'd3:    part_be = 4'hE;
      default: part_be = 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/bpc_word_fifo.sv
// Synchronous first-word-fall-through FIFO of packed codestream words.
module bpc_word_fifo
  import bpc_byte_packer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  bpc_word_t     wdata,
  input  logic          pop,
  output bpc_word_t     rdata,
  output logic [AW:0]   count,
  output logic          empty
);

  bpc_word_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // The stop_rd threshold upstream must keep the FIFO from ever overflowing.
  a_no_overflow: assert property (@(posedge clk) disable iff (clr) !(push && full));

endmodule

// File: rtl/bpc_byte_packer.sv
// Packs the arbiter's serial MQ byte stream into 32-bit big-endian words,
// closing each code-block segment with a byte-enabled last word.
module bpc_byte_packer
  import bpc_byte_packer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk_rd,
  input  logic        rst,
  input  logic        rst_syn,
  input  logic [7:0]  fifo_out,
  input  logic [9:0]  rd_vld,
  input  logic        start_aga,
  output logic        stop_rd,
  output logic [31:0] word_out,
  output logic [3:0]  word_be,
  output logic        word_last,
  output logic        word_vld,
  input  logic        word_rdy,
  output logic [15:0] byte_cnt
);

  bpc_state_t  state, state_nxt;
  logic        clr, byte_vld_d;
  logic [31:0] pack_reg, reg_nxt;
  logic [1:0]  pos, pos_nxt;
  logic        full, full_nxt;
  logic        push, pop, fifo_empty;
  bpc_word_t   push_word, head;
  logic [AW:0] fifo_cnt;

  assign clr = !rst || rst_syn;

  always_ff @(posedge clk_rd) begin
    if (clr) begin
      state      <= ST_IDLE;
      byte_vld_d <= 1'b0;
      pack_reg   <= '0;
      pos        <= '0;
      full       <= 1'b0;
      byte_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      byte_vld_d <= |rd_vld;
      pack_reg   <= reg_nxt;
      pos        <= pos_nxt;
      full       <= full_nxt;
      if (byte_vld_d && byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    reg_nxt   = pack_reg;
    pos_nxt   = pos;
    full_nxt  = full;
    push      = 1'b0;
    push_word = '0;
    case (state)
      ST_IDLE, ST_ACCUM: begin
        if (byte_vld_d) begin
          state_nxt = ST_ACCUM;
          if (full) begin
            // held word leaves as the next byte starts a fresh one
            push      = 1'b1;
            push_word = '{last: 1'b0, be: 4'hF, data: pack_reg};
            reg_nxt   = {fifo_out, 24'h0};
            pos_nxt   = 2'd1;
            full_nxt  = 1'b0;
          end else begin
            reg_nxt  = pack_reg | ({fifo_out, 24'h0} >> {pos, 3'b000});
            pos_nxt  = pos + 2'd1;
            full_nxt = (pos == 2'd3);
          end
        end else if (state == ST_ACCUM && start_aga) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        push      = 1'b1;
        push_word = '{last: 1'b1, be: (full ? 4'hF : part_be(pos)), data: pack_reg};
        reg_nxt   = '0;
        pos_nxt   = '0;
        full_nxt  = 1'b0;
        state_nxt = ST_IDLE;
        // a straggler byte opens the next segment instead of being lost
        if (byte_vld_d) begin
          reg_nxt   = {fifo_out, 24'h0};
          pos_nxt   = 2'd1;
          state_nxt = ST_ACCUM;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  bpc_word_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk_rd),
    .clr   (clr),
    .push  (push),
    .wdata (push_word),
    .pop   (pop),
    .rdata (head),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

  assign word_vld  = !fifo_empty;
  assign pop       = word_vld && word_rdy;
  assign word_out  = word_vld ? head.data : 32'h0;
  assign word_be   = word_vld ? head.be   : 4'h0;
  assign word_last = word_vld ? head.last : 1'b0;

  // Two slots of headroom: one byte still in flight and the held word.
  assign stop_rd = (int'(fifo_cnt) + 2 >= DEPTH) || (state == ST_FLUSH);

endmodule

// File: tb/tb_bpc_byte_packer.sv
// Bench for bpc_byte_packer: emulates the arbiter, models segments as byte lists
// and checks every accepted word, idle output zeros and byte_cnt each cycle.
module tb_bpc_byte_packer;

  logic        clk_rd = 1'b0;
  logic        rst, rst_syn, start_aga, stop_rd;
  logic [7:0]  fifo_out;
  logic [9:0]  rd_vld;
  logic [31:0] word_out;
  logic [3:0]  word_be;
  logic        word_last, word_vld, word_rdy;
  logic [15:0] byte_cnt;

  always #5 clk_rd = ~clk_rd;

  bpc_byte_packer #(.DEPTH(8), .AW(3)) dut (
    .clk_rd(clk_rd), .rst(rst), .rst_syn(rst_syn), .fifo_out(fifo_out), .rd_vld(rd_vld),
    .start_aga(start_aga), .stop_rd(stop_rd), .word_out(word_out), .word_be(word_be),
    .word_last(word_last), .word_vld(word_vld), .word_rdy(word_rdy), .byte_cnt(byte_cnt)
  );

  int errors = 0, checks = 0;
  logic [36:0] exp_q[$], got_q[$];
  logic [7:0]  seg[$], src[$];
  int          cnt_model = 0;
  bit          chk_en = 0, cap_flag = 0, pend_v = 0, burst = 0;
  logic [7:0]  pend;
  int          rdy_mode = 1;
  logic [36:0] e_w;
  logic [15:0] cnt_sat;

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Reference: a segment is a byte list; every 4 bytes followed by another byte
  // is a full word, the remainder at flush is the MSB-aligned last word.
  task automatic model_add(input logic [7:0] b);
    seg.push_back(b);
    if (seg.size() == 5) begin
      exp_q.push_back({1'b0, 4'hF, seg[0], seg[1], seg[2], seg[3]});
      repeat (4) void'(seg.pop_front());
    end
  endtask

  task automatic model_flush();
    logic [31:0] d;
    logic [3:0]  be;
    int n;
    n = seg.size();
    if (n > 0) begin
      d = '0;
      for (int i = 0; i < n; i++) d[31-8*i -: 8] = seg[i];
      be = 4'hF << (4 - n);
      exp_q.push_back({1'b1, be, d});
    end
    seg.delete();
  endtask

  always @(negedge clk_rd) begin
    if (chk_en) begin
      if (word_vld && word_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected none", {word_last, word_be, word_out});
        end else begin
          e_w = exp_q.pop_front();
          chk("word", {word_last, word_be, word_out}, e_w);
        end
        got_q.push_back({word_last, word_be, word_out});
      end
      if (!word_vld) chk("idle_zero", {word_last, word_be, word_out}, 37'h0);
      cnt_sat = (cnt_model > 65535) ? 16'hFFFF : 16'(cnt_model);
      chk("byte_cnt", {21'h0, byte_cnt}, {21'h0, cnt_sat});
    end
  end

  task automatic tick();
    @(posedge clk_rd);
    if (cap_flag) cnt_model++;
    #1;
    fifo_out = pend_v ? pend : 8'($urandom);
    cap_flag = pend_v;
    pend_v   = 1'b0;
    rd_vld   = '0;
    word_rdy = (rdy_mode == 2) ? 1'($urandom % 2) : 1'(rdy_mode);
  endtask

  task automatic step();
    tick();
    if (src.size() > 0 && !stop_rd && (burst || ($urandom % 3 != 0))) begin
      pend   = src.pop_front();
      pend_v = 1'b1;
      rd_vld = 10'b1 << $urandom_range(0, 9);
      model_add(pend);
    end
  endtask

  task automatic send_all();
    int k = 0;
    while (src.size() > 0 && k < 90000) begin step(); k++; end
    if (src.size() > 0) fail_now("send_timeout");
  endtask

  // start_aga lands on the cycle the last byte is captured
  task automatic flush();
    model_flush();
    tick();
    start_aga = 1'b1;
    repeat (3) tick();
    start_aga = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_q.size() > 0 || word_vld) && k < 500) begin step(); k++; end
    if (k >= 500) fail_now("drain_timeout");
  endtask

  task automatic segment(input logic [7:0] bytes[$]);
    foreach (bytes[i]) src.push_back(bytes[i]);
    send_all();
    flush();
    wait_drain();
  endtask

  initial begin
    logic [7:0] bl[$];
    rst = 1'b0; rst_syn = 1'b0; start_aga = 1'b0; fifo_out = '0; rd_vld = '0; word_rdy = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {word_last, word_be, word_out}, 37'h0);
    chk("reset_misc", {word_vld, stop_rd, byte_cnt}, 18'h0);
    rst = 1'b1;
    cnt_model = 0;
    tick();
    chk_en = 1'b1;

    // 1: five bytes, partial last word
    rdy_mode = 1; burst = 1; got_q.delete();
    segment('{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1});
    chk("t1_count", 37'(got_q.size()), 37'd2);
    if (got_q.size() == 2) begin
      chk("t1_w0", got_q[0], {1'b0, 4'hF, 32'hA1A2A3A4});
      chk("t1_w1", got_q[1], {1'b1, 4'h8, 32'hB1000000});
    end

    // 2: exactly eight bytes, full last word
    got_q.delete();
    segment('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});
    chk("t2_count", 37'(got_q.size()), 37'd2);
    if (got_q.size() == 2) begin
      chk("t2_w0", got_q[0], {1'b0, 4'hF, 32'h01020304});
      chk("t2_w1", got_q[1], {1'b1, 4'hF, 32'h05060708});
    end

    // 4: start_aga coincident with capture of C3
    got_q.delete();
    segment('{8'hC1, 8'hC2, 8'hC3});
    chk("t4_count", 37'(got_q.size()), 37'd1);
    if (got_q.size() == 1) chk("t4_w0", got_q[0], {1'b1, 4'hE, 32'hC1C2C3_00});

    // 3: downstream stalled, stream throttled without loss
    rdy_mode = 0;
    for (int i = 0; i < 40; i++) src.push_back(8'(8'h40 + i));
    repeat (60) step();
    chk("t3_stop_rd", {36'h0, stop_rd}, 37'h1);
    chk("t3_word_vld", {36'h0, word_vld}, 37'h1);
    chk("t3_throttled", {36'h0, src.size() > 0}, 37'h1);
    rdy_mode = 1;
    send_all();
    flush();
    wait_drain();
    chk("t3_released", {36'h0, stop_rd}, 37'h0);

    // 5: soft clear mid-word
    src.push_back(8'h11); src.push_back(8'h12);
    send_all();
    repeat (2) tick();
    chk_en = 1'b0;
    rst_syn = 1'b1;
    tick();
    rst_syn = 1'b0;
    seg.delete(); exp_q.delete(); cnt_model = 0;
    chk_en = 1'b1;
    chk("t5_cleared", {word_vld, stop_rd, byte_cnt}, 18'h0);
    got_q.delete();
    segment('{8'hD1, 8'hD2, 8'hD3});
    chk("t5_count", 37'(got_q.size()), 37'd1);
    if (got_q.size() == 1) chk("t5_w0", got_q[0], {1'b1, 4'hE, 32'hD1D2D3_00});

    // 6a: start_aga while idle produces nothing
    got_q.delete();
    start_aga = 1'b1;
    repeat (5) tick();
    start_aga = 1'b0;
    tick();
    chk("t6_no_empty_seg", 37'(got_q.size()), 37'd0);

    // randomized segments, random gaps and random backpressure
    rdy_mode = 2; burst = 0;
    for (int s = 0; s < 12; s++) begin
      bl.delete();
      for (int i = 0, n = $urandom_range(1, 21); i < n; i++) bl.push_back(8'($urandom));
      segment(bl);
    end

    // 6b: byte_cnt saturation
    rdy_mode = 1; burst = 1;
    for (int i = 0; i < 70000; i++) src.push_back(8'(i));
    send_all();
    flush();
    wait_drain();
    chk("t6_sat", {21'h0, byte_cnt}, {21'h0, 16'hFFFF});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
